fifo_sel_drain: RTL and testbench
=================================

// Module: fifo_sel_drain
// PURPOSE
//  Consumer side of the FIFO selection code: takes the 8-bit selection code
//  (bit7 = valid, [6:0] = FIFO index), drains exactly one packet from the
//  selected first-word-fall-through FIFO onto a ready/valid output stream, then
//  pulses a per-port release so the selector can move on. Sits between the
//  per-port input FIFOs and the shared output link.
// PARAMETERS
//  PORT_NUM  8   number of input FIFOs (1..128)
//  DATA_W    32  FIFO/output word width
//  LEN_W     8   payload-length field width, header bits [LEN_W-1:0]
//  GAP_CYC   1   idle cycles after EOP before a new code is accepted (>=1)
// PORTS
//  glb_clk        in   1                clock, all logic on rising edge
//  glb_areset     in   1                asynchronous reset, active-high
//  fifo_sel_code  in   8                [7]=valid, [6:0]=FIFO index
//  fifo_empty     in   PORT_NUM         per-FIFO empty flag
//  fifo_rd_data   in   PORT_NUM*DATA_W  FWFT head words, port i at [i*DATA_W +: DATA_W]
//  fifo_rd_en     out  PORT_NUM         one-hot pop strobe
//  out_data       out  DATA_W           output word
//  out_valid      out  1                output word valid
//  out_ready      in   1                downstream accepts word
//  out_sop        out  1                first word (header) of packet
//  out_eop        out  1                last word of packet
//  fifo_release   out  PORT_NUM         1-cycle pulse: packet from port i done
//  busy           out  1                high while not in IDLE
//  sel_err        out  1                1-cycle pulse: valid code, index >= PORT_NUM
// BEHAVIOUR
//  - States IDLE, HEAD, BODY, GAP. Reset: state IDLE, idx=0, cnt=0, gap cnt=0;
//    all outputs 0 (out_data 0 since out_valid 0 gates it to zero).
//  - beat = out_valid & out_ready. out_valid = (HEAD|BODY) & !fifo_empty[idx];
//    out_data = fifo_rd_data slice idx; fifo_rd_en[idx] = beat (combinational).
//  - IDLE: if code[7] & code[6:0] < PORT_NUM: latch idx, -> HEAD next cycle.
//    If code[7] & index out of range: sel_err pulses next cycle, stay IDLE.
//  - HEAD: out_sop=1. On beat: L = header[LEN_W-1:0]; L==0 -> out_eop=1 same
//    beat, -> GAP; else cnt<=L, -> BODY.
//  - BODY: each beat cnt<=cnt-1; out_eop=1 when cnt==1; eop beat -> GAP.
//  - GAP: fifo_release[idx] pulses on first GAP cycle (cycle after EOP beat);
//    stays GAP_CYC cycles, then IDLE. busy=0 from IDLE entry.
//  - Latency: code valid at edge N -> HEAD at N+1, first beat earliest N+1.
//  - fifo_sel_code ignored outside IDLE (changes mid-packet have no effect).
//  - FIFO empty mid-packet: out_valid=0, no pop, cnt/state hold. out_ready=0:
//    no pop, out_data holds FIFO head. Never pop an empty FIFO.
//  - Max packet = 1 + (2^LEN_W - 1) words; cnt is LEN_W bits, no wrap.
//  - Reset mid-packet: immediate return to reset values; no release pulse.
//  - busy, fifo_release, sel_err registered; datapath/handshake combinational.
// TESTING
//  1 code=0x83, FIFO3 holds {hdr L=2, D1, D2}, ready=1 -> valid N+1..N+3,
//    sop@N+1, eop@N+3, rd_en=0x08 x3, release=0x08 @N+4, busy=0 @N+5.
//  2 same packet, out_ready=1,0,1,0... -> pops only on ready=1, 3 beats total,
//    data stable while ready=0, eop on D2.
//  3 fifo_empty[3] high 2 cycles during BODY -> out_valid=0, no rd_en, then
//    resumes with correct remaining count; exactly L+1 pops.
//  4 header L=0 on FIFO5 (code 0x85) -> single beat sop=eop=1, release=0x20.
//  5 code=0x88 (PORT_NUM=8) -> sel_err pulse, no rd_en, busy stays 0;
//    code switch 0x83->0x81 mid-packet -> packet from FIFO3 completes intact.
//  6 assert glb_areset in BODY -> outputs 0 asynchronously, no release;
//    after deassert code 0x82 drains FIFO2 normally.

Source files
------------

// File: rtl/fifo_sel_drain.sv
// Drains one packet from the FWFT FIFO chosen by the selection code onto a
// ready/valid stream, then pulses a per-port release after the EOP beat.
module fifo_sel_drain #(
    parameter int PORT_NUM = 8,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8,
    parameter int GAP_CYC  = 1
) (
    input  logic                       glb_clk,
    input  logic                       glb_areset,
    input  logic [7:0]                 fifo_sel_code,
    input  logic [PORT_NUM-1:0]        fifo_empty,
    input  logic [PORT_NUM*DATA_W-1:0] fifo_rd_data,
    output logic [PORT_NUM-1:0]        fifo_rd_en,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [PORT_NUM-1:0]        fifo_release,
    output logic                       busy,
    output logic                       sel_err
);

    localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StHead,
        StBody,
        StGap
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PORT_NUM-1:0] release_q, release_d;
    logic                sel_err_q, sel_err_d;

    logic [DATA_W-1:0]   head_word;
    logic                head_empty;
    logic [PORT_NUM-1:0] idx_onehot;
    logic [LEN_W-1:0]    hdr_len;
    logic                in_pkt;
    logic                beat;
    logic                last_body;
    logic                code_vld;
    logic [6:0]          code_idx;
    logic                code_in_range;

    // Head-of-FIFO mux for the currently latched port.
    always_comb begin
        head_word  = '0;
        head_empty = 1'b1;
        idx_onehot = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                head_word     = fifo_rd_data[i*DATA_W +: DATA_W];
                head_empty    = fifo_empty[i];
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign code_vld      = fifo_sel_code[7];
    assign code_idx      = fifo_sel_code[6:0];
    assign code_in_range = int'(code_idx) < PORT_NUM;

    assign hdr_len   = head_word[LEN_W-1:0];
    assign last_body = (cnt_q == LEN_W'(1));
    assign in_pkt    = (state_q == StHead) || (state_q == StBody);

    assign out_valid = in_pkt & ~head_empty;
    assign beat      = out_valid & out_ready;
    assign out_data  = out_valid ? head_word : '0;
    assign out_sop   = out_valid & (state_q == StHead);
    assign out_eop   = out_valid & (((state_q == StHead) & (hdr_len == '0)) |
                                    ((state_q == StBody) & last_body));

    // Pop only the selected FIFO, and only on an accepted beat.
    assign fifo_rd_en = beat ? idx_onehot : '0;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        release_d = '0;
        sel_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (code_vld) begin
                    if (code_in_range) begin
                        idx_d   = code_idx[IDX_W-1:0];
                        state_d = StHead;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            StHead: begin
                if (beat) begin
                    if (hdr_len == '0) begin
                        state_d   = StGap;
                        gap_d     = '0;
                        release_d = idx_onehot;
                    end else begin
                        cnt_d   = hdr_len;
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (beat) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (last_body) begin
                        state_d   = StGap;
                        gap_d     = '0;
                        release_d = idx_onehot;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            release_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            release_q <= release_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign fifo_release = release_q;
    assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_fifo_sel_drain.sv
// Directed bench for fifo_sel_drain: FWFT FIFO models per port, scoreboard of
// expected beats and release pulses filled when packets are loaded.
module tb_fifo_sel_drain;

    localparam int PN = 8;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [7:0]      code;
    logic [PN-1:0]   fifo_empty;
    logic [PN*DW-1:0] fifo_rd_data;
    logic [PN-1:0]   fifo_rd_en;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;
    logic [PN-1:0]   fifo_release;
    logic            busy;
    logic            sel_err;

    fifo_sel_drain #(
        .PORT_NUM(PN),
        .DATA_W  (DW),
        .LEN_W   (8),
        .GAP_CYC (1)
    ) dut (
        .glb_clk      (clk),
        .glb_areset   (rst),
        .fifo_sel_code(code),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .fifo_release (fifo_release),
        .busy         (busy),
        .sel_err      (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: mem/wr_ptr written by the stimulus, rd_ptr by the pop logic.
    logic [31:0] mem [PN][32];
    int          wr_ptr [PN];
    int          rd_ptr [PN];
    logic [PN-1:0] hold_empty;

    always_comb begin
        fifo_empty   = '0;
        fifo_rd_data = '0;
        for (int i = 0; i < PN; i++) begin
            fifo_empty[i]             = (rd_ptr[i] == wr_ptr[i]) || hold_empty[i];
            fifo_rd_data[i*DW +: DW]  = mem[i][rd_ptr[i] % 32];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < PN; i++) begin
            if (fifo_rd_en[i] && !fifo_empty[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        int          port;
    } beat_t;

    beat_t      sb [$];
    logic [7:0] rel_q [$];

    int n_cmp;
    int n_err;

    logic        s_valid, s_sop, s_eop, s_busy, s_err;
    logic [31:0] s_data;
    logic [7:0]  s_rden, s_rel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int port, input int len, input logic [31:0] base);
        logic [31:0] w;
        beat_t       b;
        w = {base[23:0], 8'(len)};
        mem[port][wr_ptr[port] % 32] = w;
        wr_ptr[port]++;
        b = '{data: w, sop: 1'b1, eop: (len == 0), port: port};
        sb.push_back(b);
        for (int k = 1; k <= len; k++) begin
            w = base + 32'(k);
            mem[port][wr_ptr[port] % 32] = w;
            wr_ptr[port]++;
            b = '{data: w, sop: 1'b0, eop: (k == len), port: port};
            sb.push_back(b);
        end
        rel_q.push_back(8'(1) << port);
    endtask

    task automatic monitor();
        beat_t e;
        s_valid = out_valid;
        s_sop   = out_sop;
        s_eop   = out_eop;
        s_busy  = busy;
        s_err   = sel_err;
        s_data  = out_data;
        s_rden  = fifo_rd_en;
        s_rel   = fifo_release;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(out_data), 64'hdead);
            end else begin
                e = sb.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.data));
                chk("beat_sop", 64'(out_sop), 64'(e.sop));
                chk("beat_eop", 64'(out_eop), 64'(e.eop));
                chk("beat_rd_en", 64'(fifo_rd_en), 64'(1) << e.port);
            end
        end else begin
            chk("idle_rd_en", 64'(fifo_rd_en), 64'h0);
        end
        if (!out_valid) chk("gated_data", 64'(out_data), 64'h0);
        chk("pop_empty", 64'(fifo_rd_en & fifo_empty), 64'h0);
        if (fifo_release != '0) begin
            if (rel_q.size() == 0) chk("unexpected_release", 64'(fifo_release), 64'h0);
            else chk("release", 64'(fifo_release), 64'(rel_q.pop_front()));
        end
    endtask

    // One cycle: sample at the falling edge, then step to just past the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy || rel_q.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 64'(k < 100), 64'h1);
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'h0);
        chk({tag, "_rel_left"}, 64'(rel_q.size()), 64'h0);
    endtask

    initial begin
        logic        prev_hold;
        logic [31:0] prev_data;
        logic        rdy;
        int          pops0;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        code = 8'h00;
        out_ready = 1'b0;
        hold_empty = '0;
        for (int i = 0; i < PN; i++) begin
            wr_ptr[i] = 0;
            rd_ptr[i] = 0;
            for (int j = 0; j < 32; j++) mem[i][j] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'h0);
        chk("rst_release", 64'(fifo_release), 64'h0);
        chk("rst_sel_err", 64'(sel_err), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        rst = 1'b0;
        tick();

        // 1: basic packet, L=2 on FIFO3
        out_ready = 1'b1;
        push_pkt(3, 2, 32'h3300_0000);
        code = 8'h83;
        tick();
        chk("t1_n_valid", 64'(s_valid), 64'h0);
        chk("t1_n_busy", 64'(s_busy), 64'h0);
        code = 8'h00;
        tick();
        chk("t1_n1_valid", 64'(s_valid), 64'h1);
        chk("t1_n1_sop", 64'(s_sop), 64'h1);
        chk("t1_n1_rd_en", 64'(s_rden), 64'h08);
        tick();
        chk("t1_n2_rd_en", 64'(s_rden), 64'h08);
        chk("t1_n2_eop", 64'(s_eop), 64'h0);
        tick();
        chk("t1_n3_eop", 64'(s_eop), 64'h1);
        chk("t1_n3_rd_en", 64'(s_rden), 64'h08);
        tick();
        chk("t1_n4_release", 64'(s_rel), 64'h08);
        chk("t1_n4_valid", 64'(s_valid), 64'h0);
        chk("t1_n4_busy", 64'(s_busy), 64'h1);
        tick();
        chk("t1_n5_busy", 64'(s_busy), 64'h0);

        // 2: same packet with out_ready toggling
        push_pkt(3, 2, 32'h3310_0000);
        code = 8'h83;
        tick();
        code = 8'h00;
        prev_hold = 1'b0;
        prev_data = '0;
        rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            out_ready = rdy;
            tick();
            if (prev_hold) chk("t2_data_stable", 64'(s_data), 64'(prev_data));
            prev_hold = s_valid && !rdy;
            prev_data = s_data;
            rdy = !rdy;
        end
        out_ready = 1'b1;
        drain("t2");

        // 3: FIFO3 runs empty for two cycles mid-body
        pops0 = rd_ptr[3];
        push_pkt(3, 4, 32'h3320_0000);
        code = 8'h83;
        tick();
        code = 8'h00;
        tick();
        tick();
        hold_empty[3] = 1'b1;
        tick();
        chk("t3_stall_valid_a", 64'(s_valid), 64'h0);
        tick();
        chk("t3_stall_valid_b", 64'(s_valid), 64'h0);
        chk("t3_stall_busy", 64'(s_busy), 64'h1);
        hold_empty[3] = 1'b0;
        drain("t3");
        chk("t3_pop_count", 64'(rd_ptr[3] - pops0), 64'd5);

        // 4: zero-length packet on FIFO5
        push_pkt(5, 0, 32'h5500_1200);
        code = 8'h85;
        tick();
        code = 8'h00;
        tick();
        chk("t4_sop", 64'(s_sop), 64'h1);
        chk("t4_eop", 64'(s_eop), 64'h1);
        drain("t4");

        // 5: out-of-range code, then a code change mid-packet
        code = 8'h88;
        tick();
        code = 8'h00;
        tick();
        chk("t5_sel_err", 64'(s_err), 64'h1);
        chk("t5_err_busy", 64'(s_busy), 64'h0);
        tick();
        chk("t5_sel_err_clr", 64'(s_err), 64'h0);
        chk("t5_err_no_pop", 64'(s_rden), 64'h0);
        push_pkt(3, 2, 32'h3330_0000);
        push_pkt(1, 1, 32'h1100_0000);
        code = 8'h83;
        tick();
        code = 8'h81;
        repeat (6) tick();
        code = 8'h00;
        drain("t5");

        // 6: reset in BODY, then a clean packet from FIFO2
        push_pkt(4, 5, 32'h4400_0000);
        code = 8'h84;
        tick();
        code = 8'h00;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'h0);
        chk("t6_rst_rd_en", 64'(fifo_rd_en), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_sop_eop", 64'({out_sop, out_eop}), 64'h0);
        chk("t6_rst_data", 64'(out_data), 64'h0);
        sb.delete();
        rel_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        push_pkt(2, 3, 32'h2200_0000);
        code = 8'h82;
        tick();
        code = 8'h00;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
